// File: rtl/gray_pkg.sv
// Shared Gray/binary pointer helpers for the dual-clock pointer path.
// Functions work on a zero-extended word so any pointer width up to GRAY_MAX_W can use them.
package gray_pkg;

    localparam int GRAY_MAX_W    = 32;
    localparam int GRAY_SYNC_MIN = 2;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits leave the prefix XOR unchanged, so truncating the result is exact.
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr_rx_if.sv
// Consumer-facing read handshake and status of the Gray pointer receiver.
// master = consumer, slave = gray_ptr_rx.
interface gray_ptr_rx_if #(
    parameter int PTR_W = 4
);
    logic             rd_req;
    logic             rd_ack;
    logic [PTR_W-2:0] rd_addr;
    logic [PTR_W-1:0] level;
    logic             empty;

    modport master (
        output rd_req,
        input  rd_ack,
        input  rd_addr,
        input  level,
        input  empty
    );

    modport slave (
        input  rd_req,
        output rd_ack,
        output rd_addr,
        output level,
        output empty
    );
endinterface

// File: rtl/gray_bus_sync.sv
// Purpose: STAGES-deep flop chain synchronizing a Gray-coded bus into clk.
// Latency: STAGES clk edges from d to q.
// Backpressure: none; samples every cycle.
module gray_bus_sync #(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gray_ptr_rx.sv
// Purpose: read-side Gray pointer receiver (sync, decode, empty/level, rd handshake); GRAY_PTR_RX_STEP_CHECK_EN adds sticky step_err.
// Latency: gray_in -> wr_bin/empty/level in SYNC_STAGES+1 edges; rd_ack same cycle as rd_req, pointer moves on next edge.
// Backpressure: rd_req while empty is ignored (no ack); one ack per cycle while non-empty.
module gray_ptr_rx
    import gray_pkg::*;
#(
    parameter int PTR_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PTR_W-1:0] gray_in,
    gray_ptr_rx_if.slave     rd_if,
    output logic [PTR_W-1:0] rd_gray,
    output logic [PTR_W-1:0] wr_bin,
    output logic             step_err
);

    // A single flop is never enough to resolve metastability.
    localparam int STAGES_EFF = (SYNC_STAGES < GRAY_SYNC_MIN) ? GRAY_SYNC_MIN : SYNC_STAGES;

    logic [PTR_W-1:0] g_sync;
    logic [PTR_W-1:0] wr_bin_q;
    logic [PTR_W-1:0] rd_bin_q;
    logic [PTR_W-1:0] rd_bin_nxt;
    logic [PTR_W-1:0] rd_gray_q;
    logic [PTR_W-1:0] level;
    logic             empty;
    logic             rd_ack;

    gray_bus_sync #(
        .W      (PTR_W),
        .STAGES (STAGES_EFF)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gray_in),
        .q     (g_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bin_q  <= '0;
            rd_bin_q  <= '0;
            rd_gray_q <= '0;
        end else begin
            wr_bin_q  <= PTR_W'(gray2bin(gray_word_t'(g_sync)));
            rd_bin_q  <= rd_bin_nxt;
            rd_gray_q <= PTR_W'(bin2gray(gray_word_t'(rd_bin_nxt)));
        end
    end

    assign empty      = (wr_bin_q == rd_bin_q);
    assign level      = wr_bin_q - rd_bin_q;
    assign rd_ack     = rd_if.rd_req & ~empty;
    assign rd_bin_nxt = rd_bin_q + {{(PTR_W-1){1'b0}}, rd_ack};

    assign rd_if.rd_ack  = rd_ack;
    assign rd_if.rd_addr = rd_bin_q[PTR_W-2:0];
    assign rd_if.level   = level;
    assign rd_if.empty   = empty;
    assign rd_gray       = rd_gray_q;
    assign wr_bin        = wr_bin_q;

`ifdef GRAY_PTR_RX_STEP_CHECK_EN
    localparam logic [PTR_W-1:0] CAPACITY = {1'b1, {(PTR_W-1){1'b0}}};

    logic [PTR_W-1:0] g_prev;
    logic [PTR_W-1:0] g_diff;
    logic             multi_bit;
    logic             over_fill;
    logic             step_err_q;

    // More than one toggled bit between samples means the writer skipped a Gray step.
    assign g_diff    = g_sync ^ g_prev;
    assign multi_bit = |(g_diff & (g_diff - PTR_W'(1)));
    assign over_fill = (level > CAPACITY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_prev     <= '0;
            step_err_q <= 1'b0;
        end else begin
            g_prev <= g_sync;
            if (multi_bit || over_fill) begin
                step_err_q <= 1'b1;
            end
        end
    end

    assign step_err = step_err_q;
`else
    assign step_err = 1'b0;
`endif

endmodule

// File: doc/gray_ptr_rx.md
# gray_ptr_rx

Read-side pointer receiver for a Gray-coded pointer crossing from another clock domain. It synchronizes the incoming Gray pointer and decodes it to binary. It compares the result against a local read pointer to produce empty/level status and a read handshake, and returns the local read pointer Gray-encoded for the writer side. It is the decoding/consuming end of the codebase's binary-to-Gray pointer path and sits at the read port of a dual-clock buffer.

## Interface
- `PTR_W`, default 4: pointer width including wrap bit; buffer capacity is 2^(PTR_W-1) entries.
- `SYNC_STAGES`, default 2, minimum 2: synchronizer flop count on `gray_in`.
- `clk`  in  1: read-domain clock; all state on rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `gray_in`  in  PTR_W: writer's Gray-coded pointer, asynchronous to `clk`.
- `rd_req`  in  1: consumer requests one entry.
- `rd_ack`  out  1: entry consumed this cycle.
- `rd_addr`  out  PTR_W-1: buffer address of the current head entry (rd_bin without wrap bit).
- `rd_gray`  out  PTR_W: registered Gray encoding of the local read pointer, for the writer domain.
- `wr_bin`  out  PTR_W: decoded, synchronized writer pointer.
- `level`  out  PTR_W: entries available.
- `empty`  out  1: no entries available.
- `step_err`  out  1: sticky protocol error flag.

## Operation
- Sync: `gray_in` passes through SYNC_STAGES flops, giving `g_sync`.
- Decode: `wr_bin` register <= gray2bin(`g_sync`) every cycle. Bit i is the XOR of `g_sync`[PTR_W-1:i].
- Local pointer: `rd_bin` is a PTR_W-bit register that increments by 1 on `rd_ack` and wraps modulo 2^PTR_W.
- `rd_gray` register <= bin2gray(next `rd_bin`), so it always equals bin2gray(`rd_bin`) after each edge.
- `empty` = (`wr_bin` == `rd_bin`), combinational from registers.
- `level` = (`wr_bin` − `rd_bin`) mod 2^PTR_W.
- `rd_ack` = `rd_req` & !`empty`, combinational. `rd_req` while empty is ignored: no ack, pointer unchanged, no error.
- Simultaneous events: a `wr_bin` update and an `rd_ack` in the same cycle both take effect. `level` next cycle reflects both.
- Wrap-around: at PTR_W=4, `rd_bin` goes 15 -> 0 and `wr_bin` goes 15 -> 0 via Gray 1000 -> 0000. `level` arithmetic is modulo, so it stays correct across the wrap.

## Timing
- Reset values: all sync flops, `wr_bin`, `rd_bin` = 0; `rd_gray` = 0; `empty` = 1; `level` = 0; `rd_ack` = 0; `step_err` = 0.
- Latency from a `gray_in` change to `wr_bin`/`empty`/`level` update: SYNC_STAGES + 1 `clk` edges.
- `rd_ack` is in the same cycle as `rd_req`. The `rd_addr`/`level`/`rd_gray` change is visible after the following edge.
- Back-to-back reads: one ack per cycle while non-empty.
- Reset mid-operation: asserting `rst_n` low immediately returns all state to reset values. The writer side must be reset with it; no partial recovery.

## Configuration
- `GRAY_PTR_RX_STEP_CHECK_EN` defined:
  - `step_err` sets when consecutive `g_sync` samples differ in more than one bit.
  - `step_err` also sets when computed `level` > 2^(PTR_W-1).
  - It stays set until reset.
- Undefined: `step_err` tied to 0 and no check logic is present.

## Structure
- Shared package `gray_pkg`:
  - Functions `bin2gray`, `gray2bin` (width-generic via PTR_W).
  - Constant `GRAY_SYNC_MIN = 2`.
- One sub-module, `gray_bus_sync`: a parameterized SYNC_STAGES-deep flop chain on a PTR_W-bit bus with async active-low reset. All metastability handling lives there.

## Test plan
- Reset: hold `rst_n`=0 with `gray_in`=0110 -> `empty`=1, `level`=0, `rd_gray`=0000, `step_err`=0. Release -> `wr_bin`=0100 after SYNC_STAGES+1 edges.
- Single step: `gray_in` 0000 -> 0001 -> `empty` falls exactly 3 edges later (SYNC_STAGES=2), `level`=1. Then `rd_req`=1 for one cycle -> `rd_ack`=1, then `empty`=1, `rd_gray`=0001, `rd_addr`=001.
- Fill and drain: step the writer Gray sequence to bin 8 -> `level`=8. Then 8 consecutive `rd_req` -> 8 acks in 8 cycles, and a 9th `rd_req` -> `rd_ack`=0.
- Wrap plus simultaneity:
  - Writer steps from bin 14 to bin 2 through the 15 -> 0 wrap, while reads are taken in the same cycles as `wr_bin` updates.
  - Required: `level` stays correct modulo 16.
  - Required: `rd_gray` follows 1001, 1000, 0000, 0001.
- Step error (macro defined): `gray_in` jumps 0000 -> 0011 -> `step_err`=1 after sync and stays set. With the macro undefined, `step_err` stays 0.
- Reset mid-read: pull `rst_n` low during a burst at `level`=5 -> outputs return to reset values asynchronously, and no `rd_ack` occurs while reset is low.
